// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI slave receiver: FSM states, SPI mode
// encodings, default CRC constants and the bitwise CRC update function.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } spi_rx_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int         CRC_WIDTH_DEF = 8;
  localparam logic [7:0] CRC_POLY_DEF  = 8'h2F;
  localparam logic [7:0] CRC_INIT_DEF  = 8'hFF;
  localparam logic [7:0] CRC_FINAL_DEF = 8'hFF;

  // MSB-first CRC over data_w bits of word; poly carries no implicit top bit.
  function automatic logic [31:0] crc_update(
    input logic [31:0] crc,
    input logic [31:0] word,
    input int          crc_w,
    input int          data_w,
    input logic [31:0] poly
  );
    logic [31:0] mask;
    logic [31:0] c;
    logic        fb;
    mask = (32'h1 << crc_w) - 32'h1;
    c    = crc & mask;
    for (int i = data_w - 1; i >= 0; i--) begin
      fb = c[5'(crc_w - 1)] ^ word[5'(i)];
      c  = (c << 1) & mask;
      if (fb) begin
        c = c ^ (poly & mask);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin; RST_VAL sets the
// value held during reset (1 for chip select, 0 for the others).
module spi_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstb,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receive front-end: oversampled pins, LSB-first deserialiser,
// valid/ready word output and per-frame status. Frame CRC check is built
// only when SPI_RX_CRC_EN is defined; otherwise crc_ok is tied low.
module spi_slave_rx
  import spi_rx_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = CRC_WIDTH_DEF,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY   = CRC_WIDTH'(CRC_POLY_DEF),
  parameter logic [CRC_WIDTH-1:0] CRC_INIT   = CRC_WIDTH'(CRC_INIT_DEF),
  parameter logic [CRC_WIDTH-1:0] CRC_FINAL  = CRC_WIDTH'(CRC_FINAL_DEF),
  parameter int                   CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [1:0]            cfg_mode,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  csb,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_words,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  crc_ok
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic sclk_s;
  logic mosi_s;
  logic csb_s;
  logic sclk_d1_q;

  spi_rx_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rstb(rstb), .d_i(sclk), .q_o(sclk_s));
  spi_rx_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rstb(rstb), .d_i(mosi), .q_o(mosi_s));
  spi_rx_sync #(.RST_VAL(1'b1)) u_sync_csb  (.clk(clk), .rstb(rstb), .d_i(csb),  .q_o(csb_s));

  spi_rx_state_t         state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0]  frame_words_q, frame_words_d;
  logic                  frame_err_q, frame_err_d;
`ifdef SPI_RX_CRC_EN
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CRC_WIDTH-1:0]  crc_prev_q, crc_prev_d;
  logic [DATA_WIDTH-1:0] last_word_q, last_word_d;
  logic                  crc_ok_q, crc_ok_d;
`endif

  logic                  sample_on_rise;
  logic                  sample_edge;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] word_full;

  assign sample_on_rise = (mode_q == MODE0) || (mode_q == MODE3);
  assign sample_edge    = sample_on_rise ? (sclk_s & ~sclk_d1_q) : (~sclk_s & sclk_d1_q);
  assign handshake      = rx_valid_q & rx_ready;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    word_cnt_d    = word_cnt_q;
    overrun_d     = overrun_q;
    frame_words_d = frame_words_q;
    frame_err_d   = frame_err_q;
`ifdef SPI_RX_CRC_EN
    crc_d         = crc_q;
    crc_prev_d    = crc_prev_q;
    last_word_d   = last_word_q;
    crc_ok_d      = crc_ok_q;
`endif
    word_full                 = shift_q;
    word_full[DATA_WIDTH-1]   = mosi_s;

    // The consumer may drain the holding register in any state.
    if (handshake) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        mode_d = cfg_mode;
        if (!csb_s) begin
          state_d    = ARMED;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          overrun_d  = 1'b0;
`ifdef SPI_RX_CRC_EN
          crc_d      = CRC_INIT;
          crc_prev_d = CRC_INIT;
`endif
        end
      end
      ARMED: begin
        if (csb_s) begin
          state_d       = DONE;
          frame_words_d = word_cnt_q;
          frame_err_d   = (bit_cnt_q != '0);
`ifdef SPI_RX_CRC_EN
          crc_ok_d      = (word_cnt_q >= CNT_WIDTH'(2)) &&
                          ((crc_prev_q ^ CRC_FINAL) == last_word_q[CRC_WIDTH-1:0]);
`endif
        end else if (sample_edge) begin
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            // A same-cycle handshake frees the holding register for the new word.
            if (!rx_valid_q || handshake) begin
              rx_data_d  = word_full;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (word_cnt_q != '1) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
`ifdef SPI_RX_CRC_EN
            crc_prev_d  = crc_q;
            crc_d       = CRC_WIDTH'(crc_update(32'(crc_q), 32'(word_full), CRC_WIDTH,
                                                DATA_WIDTH, 32'(CRC_POLY)));
            last_word_d = word_full;
`endif
          end else begin
            shift_d[bit_cnt_q] = mosi_s;
            bit_cnt_d          = bit_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      sclk_d1_q     <= 1'b0;
      mode_q        <= 2'b11;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      word_cnt_q    <= '0;
      overrun_q     <= 1'b0;
      frame_words_q <= '0;
      frame_err_q   <= 1'b0;
`ifdef SPI_RX_CRC_EN
      crc_q         <= CRC_INIT;
      crc_prev_q    <= CRC_INIT;
      last_word_q   <= '0;
      crc_ok_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sclk_d1_q     <= sclk_s;
      mode_q        <= mode_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      word_cnt_q    <= word_cnt_d;
      overrun_q     <= overrun_d;
      frame_words_q <= frame_words_d;
      frame_err_q   <= frame_err_d;
`ifdef SPI_RX_CRC_EN
      crc_q         <= crc_d;
      crc_prev_q    <= crc_prev_d;
      last_word_q   <= last_word_d;
      crc_ok_q      <= crc_ok_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_done  = (state_q == DONE);
  assign frame_words = frame_words_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
`ifdef SPI_RX_CRC_EN
  assign crc_ok      = crc_ok_q;
`else
  assign crc_ok      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames in all four modes and
// checks words, frame status, overrun, reset and (with SPI_RX_CRC_EN) CRC.
module tb_spi_slave_rx;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rstb;
  logic [1:0] cfg_mode;
  logic       sclk;
  logic       mosi;
  logic       csb;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_done;
  logic [7:0] frame_words;
  logic       frame_err;
  logic       overrun;
  logic       crc_ok;

  logic       cpol;
  int         pass_cnt  = 0;
  int         check_cnt = 0;
  int         done_cnt  = 0;
  logic [7:0] rx_q[$];

  spi_slave_rx dut (
    .clk(clk), .rstb(rstb), .cfg_mode(cfg_mode), .sclk(sclk), .mosi(mosi), .csb(csb),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_done(frame_done), .frame_words(frame_words), .frame_err(frame_err),
    .overrun(overrun), .crc_ok(crc_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    if (frame_done) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pop_word(output logic [7:0] w);
    if (rx_q.size() == 0) w = 8'hxx;
    else w = rx_q.pop_front();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 rx_ready = v;
  endtask

  task automatic start_frame(input logic [1:0] mode);
    cfg_mode = mode;
    cpol     = mode[1];
    sclk     = cpol;
    repeat (4) @(negedge clk);
    csb = 1'b0;
    #T;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = w[i];
      #T sclk = ~cpol;
      #T sclk = cpol;
      #T;
    end
  endtask

  task automatic end_frame();
    csb = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] crc_msg [10];
    int         exp_done;
    crc_msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hDF};

    rstb = 1'b0; csb = 1'b1; sclk = 1'b1; mosi = 1'b0; cfg_mode = 2'b11; rx_ready = 1'b0;
    cpol = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_words", frame_words, 0);
    check("rst_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_crc_ok", crc_ok, 0);
    rstb = 1'b1;
    set_ready(1'b1);

    // mode 3 single word
    exp_done = done_cnt + 1;
    start_frame(2'b11);
    send_bits(8'hA5, 8);
    end_frame();
    check("t1_count", rx_q.size(), 1);
    pop_word(w);
    check("t1_data", w, 8'hA5);
    check("t1_words", frame_words, 1);
    check("t1_err", frame_err, 0);
    check("t1_done_pulses", done_cnt, exp_done);

    // modes 0,1,2
    for (int m = 0; m < 3; m++) begin
      start_frame(2'(m));
      send_bits(8'h3C, 8);
      end_frame();
      check($sformatf("t2_mode%0d_count", m), rx_q.size(), 1);
      pop_word(w);
      check($sformatf("t2_mode%0d_data", m), w, 8'h3C);
    end

    // CRC frame, good then corrupted trailer
    for (int pass = 0; pass < 2; pass++) begin
      start_frame(2'b00);
      for (int k = 0; k < 10; k++) begin
        w = crc_msg[k];
        if (k == 9 && pass == 1) w = 8'hDE;
        send_bits(w, 8);
      end
      end_frame();
      check($sformatf("t3_p%0d_count", pass), rx_q.size(), 10);
      check($sformatf("t3_p%0d_words", pass), frame_words, 10);
`ifdef SPI_RX_CRC_EN
      check($sformatf("t3_p%0d_crc_ok", pass), crc_ok, (pass == 0) ? 1 : 0);
`else
      check($sformatf("t3_p%0d_crc_ok", pass), crc_ok, 0);
`endif
      w = rx_q[9];
      check($sformatf("t3_p%0d_last", pass), w, (pass == 0) ? 8'hDF : 8'hDE);
      rx_q.delete();
    end

    // backpressure and overrun
    set_ready(1'b0);
    start_frame(2'b11);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    end_frame();
    check("t4_valid", rx_valid, 1);
    check("t4_data", rx_data, 8'h11);
    check("t4_overrun", overrun, 1);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    check("t4_valid_after_hs", rx_valid, 0);
    pop_word(w);
    check("t4_popped", w, 8'h11);
    check("t4_overrun_sticky", overrun, 1);
    start_frame(2'b11);
    check("t4_overrun_cleared", overrun, 0);
    set_ready(1'b1);
    send_bits(8'h77, 8);
    end_frame();
    pop_word(w);
    check("t4_next_word", w, 8'h77);

    // partial second word
    start_frame(2'b11);
    send_bits(8'h81, 8);
    send_bits(8'hFF, 5);
    end_frame();
    check("t5_count", rx_q.size(), 1);
    pop_word(w);
    check("t5_data", w, 8'h81);
    check("t5_words", frame_words, 1);
    check("t5_err", frame_err, 1);

    // reset mid-word
    set_ready(1'b0);
    start_frame(2'b11);
    send_bits(8'hC3, 8);
    send_bits(8'h0F, 4);
    check("t6_valid_pre", rx_valid, 1);
    #3 rstb = 1'b0;
    #1;
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_words", frame_words, 0);
    check("t6_rst_err", frame_err, 0);
    check("t6_rst_done", frame_done, 0);
    csb = 1'b1;
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    set_ready(1'b1);
    start_frame(2'b11);
    send_bits(8'h5A, 8);
    end_frame();
    check("t6_count", rx_q.size(), 1);
    pop_word(w);
    check("t6_data", w, 8'h5A);
    check("t6_words", frame_words, 1);
    check("t6_err", frame_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
